// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, captures CDB results,
// answers operand-readiness queries and retires or flushes in program order.
module reorder_buffer #(
    parameter int ROB_SZ = 8,
    parameter int TAG_W  = $clog2(ROB_SZ + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             dispatch_valid,
    input  logic             dispatch_rd_valid,
    input  logic [4:0]       dispatch_dest_reg,
    input  logic [31:0]      dispatch_pc,
    output logic             rob_full,
    output logic             rob_empty,
    output logic [TAG_W-1:0] tail_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             cdb_mispredict,
    input  logic [31:0]      cdb_target,
    input  logic [TAG_W-1:0] query_tag_a,
    input  logic [TAG_W-1:0] query_tag_b,
    output logic             query_ready_a,
    output logic             query_ready_b,
    output logic [31:0]      query_value_a,
    output logic [31:0]      query_value_b,
    output logic             retire_valid,
    output logic [TAG_W-1:0] retire_tag,
    output logic             retire_rd_valid,
    output logic [4:0]       retire_dest_reg,
    output logic [31:0]      retire_value,
    output logic             flush,
    output logic [31:0]      flush_pc
);

    localparam int PTR_W = $clog2(ROB_SZ);
    localparam logic [TAG_W-1:0] ZERO_REG = '0;
    localparam logic [TAG_W-1:0] MAX_TAG  = TAG_W'(ROB_SZ);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(ROB_SZ);

    logic [ROB_SZ-1:0]        e_valid, e_complete, e_mispredict, e_rd_valid;
    logic [ROB_SZ-1:0][4:0]   e_dest;
    logic [ROB_SZ-1:0][31:0]  e_pc, e_value, e_target;

    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;

    logic             alloc;
    logic             cdb_hit;
    logic [PTR_W-1:0] cdb_idx;
    logic [32:0]      look_a, look_b;
    logic             unused_pc;

    // PC is kept per entry for debug/exception use; nothing in this block reads it
    assign unused_pc = ^e_pc;

    assign rob_full  = (count == FULL_CNT);
    assign rob_empty = (count == '0);
    assign tail_tag  = TAG_W'(tail) + TAG_W'(1);

    assign retire_valid = e_valid[head] && e_complete[head];
    assign flush        = retire_valid && e_mispredict[head];
    assign alloc        = dispatch_valid && !rob_full && !flush;

    assign cdb_idx = PTR_W'(cdb_tag - TAG_W'(1));
    assign cdb_hit = cdb_valid && (cdb_tag != ZERO_REG) && (cdb_tag <= MAX_TAG)
                     && e_valid[cdb_idx];

    // retire/flush data is zeroed when not retiring so idle outputs stay quiet
    assign retire_tag      = retire_valid ? TAG_W'(head) + TAG_W'(1) : '0;
    assign retire_rd_valid = retire_valid && e_rd_valid[head];
    assign retire_dest_reg = retire_valid ? e_dest[head]   : '0;
    assign retire_value    = retire_valid ? e_value[head]  : '0;
    assign flush_pc        = flush        ? e_target[head] : '0;

    function automatic logic [32:0] lookup(input logic [TAG_W-1:0] tag);
        logic [PTR_W-1:0] idx;
        idx = PTR_W'(tag - TAG_W'(1));
        if (tag == ZERO_REG)
            return {1'b1, 32'h0};
        if (cdb_valid && (cdb_tag == tag))
            return {1'b1, cdb_value};
        if ((tag <= MAX_TAG) && e_valid[idx] && e_complete[idx])
            return {1'b1, e_value[idx]};
        return '0;
    endfunction

    always_comb begin
        look_a = lookup(query_tag_a);
        look_b = lookup(query_tag_b);
    end

    assign query_ready_a = look_a[32];
    assign query_value_a = look_a[31:0];
    assign query_ready_b = look_b[32];
    assign query_value_b = look_b[31:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            e_valid      <= '0;
            e_complete   <= '0;
            e_mispredict <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else if (flush) begin
            e_valid      <= '0;
            e_complete   <= '0;
            e_mispredict <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else begin
            if (cdb_hit) begin
                e_complete[cdb_idx]   <= 1'b1;
                e_mispredict[cdb_idx] <= cdb_mispredict;
            end
            if (alloc) begin
                e_valid[tail]      <= 1'b1;
                e_complete[tail]   <= 1'b0;
                e_mispredict[tail] <= 1'b0;
                tail               <= tail + PTR_W'(1);
            end
            // head clear is last so it wins over a late CDB to the retiring entry
            if (retire_valid) begin
                e_valid[head]      <= 1'b0;
                e_complete[head]   <= 1'b0;
                e_mispredict[head] <= 1'b0;
                head               <= head + PTR_W'(1);
            end
            case ({alloc, retire_valid})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: ;
            endcase
        end
    end

    // payload is only observable through valid/complete-gated paths, so no reset
    always_ff @(posedge clock) begin
        if (alloc) begin
            e_rd_valid[tail] <= dispatch_rd_valid;
            e_dest[tail]     <= dispatch_dest_reg;
            e_pc[tail]       <= dispatch_pc;
        end
        if (cdb_hit) begin
            e_value[cdb_idx]  <= cdb_value;
            e_target[cdb_idx] <= cdb_target;
        end
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the out-of-order RISC-V core. It allocates one entry per dispatched instruction and returns that entry's tag, which the map table records as the producer of the destination register. It captures results from the CDB and serves operand-readiness lookups for the map-table tags read at dispatch. It retires completed entries in program order and flushes on a mispredicted branch at the head.

## Interface
Parameters:
- ROB_SZ, 8: number of entries. Must be a power of two, ≥2.
- TAG_W, $clog2(ROB_SZ+1): tag width. Tag = entry index + 1; tag 0 (`ZERO_REG`) means "value is in the register file".

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dispatch_valid  in  1  allocate an entry this cycle.
- dispatch_rd_valid  in  1  instruction writes a destination register.
- dispatch_dest_reg  in  5  architectural destination.
- dispatch_pc  in  32  PC of the instruction.
- rob_full  out  1  no free entry. Registered-count based.
- rob_empty  out  1  no valid entries.
- tail_tag  out  TAG_W  tag the next dispatch will receive.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  producing entry.
- cdb_value  in  32  result.
- cdb_mispredict  in  1  branch resolved mispredicted.
- cdb_target  in  32  correct next PC for that branch.
- query_tag_a, query_tag_b  in  TAG_W  tags from the map table.
- query_ready_a, query_ready_b  out  1  value available.
- query_value_a, query_value_b  out  32  value when ready.
- retire_valid  out  1  head entry retires this cycle.
- retire_tag  out  TAG_W  tag of the retiring entry. The map table clears matching mappings.
- retire_rd_valid  out  1  copied from the entry.
- retire_dest_reg  out  5  copied from the entry.
- retire_value  out  32  copied from the entry.
- flush  out  1  squash the whole pipeline.
- flush_pc  out  32  redirect target.

## Operation
- State per entry: valid, complete, rd_valid, dest_reg, pc, value, mispredict, target.
- Pointers: head and tail, each log2(ROB_SZ) bits, wrapping modulo ROB_SZ. Count is log2(ROB_SZ)+1 bits.
- Allocation occurs when `dispatch_valid && !rob_full && !flush`.
  - Write entry[tail] with valid=1, complete=0.
  - Advance tail.
  - `tail_tag` = tail+1.
- CDB capture occurs when `cdb_valid` and entry[cdb_tag-1] is valid.
  - Set complete=1.
  - Store value, mispredict and target.
  - A CDB with tag 0, or targeting an invalid entry, is ignored.
- Retire (combinational): `retire_valid` = entry[head].valid && entry[head].complete.
  - The retire_* outputs mirror entry[head].
  - On the clock edge after retire_valid: clear entry[head] and advance head.
- Flush (combinational): `flush` = retire_valid && entry[head].mispredict, with `flush_pc` = entry[head].target.
  - The mispredicted branch itself still retires that cycle.
  - On the next edge, all valid bits clear, head=tail=0 and count=0.
  - Allocation is suppressed in the flush cycle.
- Query lookup, per port:
  - Tag 0 → ready=1, value=0 (the register file supplies the value).
  - CDB bypass: cdb_valid and cdb_tag==query → ready=1, value=cdb_value.
  - Otherwise ready = entry[tag-1].valid && complete, and value = the stored value.
- Count update: count += alloc − retire. It is unchanged when both occur in the same cycle.

## Timing
- Reset (async, when reset_n=0):
  - All entries invalid; head=tail=count=0.
  - rob_empty=1, rob_full=0, tail_tag=1.
  - retire_valid=0, flush=0, and every data output 0.
- Dispatch-to-visible latency: 1 cycle. An entry allocated at edge N can be queried or retired from cycle N+1.
- CDB-to-retire: a result captured at edge N makes retire_valid assert in cycle N+1 if that entry is at head. A CDB in the same cycle does not retire the head early.
- Full: `rob_full` = (count==ROB_SZ).
  - Dispatch while full is dropped, even if a retire occurs the same cycle.
  - The dispatch stage must hold the instruction.
- Empty: retire_valid=0.
- Wrap-around: the pointer advances from ROB_SZ−1 to 0. Tags stay 1..ROB_SZ.
- Simultaneous CDB to the head entry and retire of the previous head: both take effect; the next entry retires the following cycle.
- reset_n asserted mid-operation discards all in-flight entries immediately.

## Test plan
- Reset, then 3 dispatches (rd=x5,x6,x7) → tail_tag 1,2,3 returned in order; count=3; no retire_valid.
- CDB tag 2 value 0xAA before tag 1 → no retire. Then CDB tag 1 value 0x11 → retire tag1 (x5, 0x11) next cycle, then tag2 (x6, 0xAA) the cycle after, in order.
- Fill 8 entries → rob_full=1. A 9th dispatch with a simultaneous retire is dropped; tail_tag unchanged. After the retire, a dispatch is accepted at tag 1, exercising wrap.
- query_tag_a=3 while cdb_tag=3 value 0x55 same cycle → query_ready_a=1, query_value_a=0x55. query_tag_b=0 → ready=1.
- Branch at tag 1 completes with cdb_mispredict=1, target 0x100, and 4 younger entries are valid → flush=1, flush_pc=0x100 in its retire cycle. Next cycle rob_empty=1, tail_tag=1, and a dispatch during the flush cycle is ignored.
- Drop reset_n low mid-stream with 5 entries valid → outputs return to reset values without waiting for a clock edge.
